// File: rtl/scratch_write_controller_pkg.sv
// Shared types and helpers for the scratchpad write controller.
// Holds the FSM state encoding, default geometry and small arithmetic helpers.
package scratch_write_controller_pkg;

  localparam int unsigned DefCellSize    = 8;
  localparam int unsigned DefAddressSize = 8;
  localparam int unsigned DefCellNums    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StFilter,
    StStream,
    StDone
  } state_e;

  function automatic int unsigned mod_inc(input int unsigned value, input int unsigned modulus);
    return (value + 1 >= modulus) ? 0 : value + 1;
  endfunction

  // Out-of-range requests (0 or larger than the scratchpad) load the whole scratchpad.
  function automatic int unsigned sat_size(input int unsigned req, input int unsigned cap);
    return (req == 0 || req > cap) ? cap : req;
  endfunction

endpackage

// File: rtl/scratch_write_controller_mod_counter.sv
// Modulo-N write pointer with synchronous clear and increment.
// q_next is the value the pointer takes on the next increment.
module scratch_write_controller_mod_counter
  import scratch_write_controller_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = WIDTH'(mod_inc(32'(q), MODULUS));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/scratch_write_controller.sv
// Producer side of the checker/scratchpad interface: drains the filter FIFO once per
// filter and the IF FIFO continuously into a circular scratchpad, never overrunning start_if.
module scratch_write_controller
  import scratch_write_controller_pkg::*;
#(
  parameter int unsigned IF_CELL_SIZE        = DefCellSize,
  parameter int unsigned IF_ADDRESS_SIZE     = DefAddressSize,
  parameter int unsigned FILTER_CELL_SIZE    = DefCellSize,
  parameter int unsigned FILTER_ADDRESS_SIZE = DefAddressSize,
  parameter int unsigned CELL_NUMS_IF        = DefCellNums,
  parameter int unsigned CELL_NUMS_FILTER    = DefCellNums
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [2:0]                     filter_size,
  input  logic                           filter_reload,
  input  logic                           done_in,
  input  logic [IF_ADDRESS_SIZE-1:0]     start_if,
  input  logic                           if_fifo_empty,
  input  logic [IF_CELL_SIZE-1:0]        if_fifo_dout,
  input  logic                           filter_fifo_empty,
  input  logic [FILTER_CELL_SIZE-1:0]    filter_fifo_dout,
  output logic                           if_fifo_rd,
  output logic                           filter_fifo_rd,
  output logic                           if_wen,
  output logic [IF_CELL_SIZE-1:0]        if_wdata,
  output logic [IF_ADDRESS_SIZE-1:0]     write_addr_if,
  output logic                           filter_wen,
  output logic [FILTER_CELL_SIZE-1:0]    filter_wdata,
  output logic [FILTER_ADDRESS_SIZE-1:0] write_addr_filter,
  output logic                           filter_loaded,
  output logic                           if_full,
  output logic                           busy
);

  state_e state_q, state_d;
  logic   filter_loaded_q, filter_loaded_d;

  logic                           if_clr, filter_clr;
  logic                           if_wr, filter_wr, filter_last;
  logic [IF_ADDRESS_SIZE-1:0]     if_q_next;
  logic [FILTER_ADDRESS_SIZE-1:0] filter_q_next;
  int unsigned                    filter_words;

  // The filter pointer never wraps, so its modulus leaves room to show "all loaded".
  scratch_write_controller_mod_counter #(
    .WIDTH  (FILTER_ADDRESS_SIZE),
    .MODULUS(CELL_NUMS_FILTER + 1)
  ) u_filter_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr   (filter_clr),
    .inc   (filter_wr),
    .q     (write_addr_filter),
    .q_next(filter_q_next)
  );

  scratch_write_controller_mod_counter #(
    .WIDTH  (IF_ADDRESS_SIZE),
    .MODULUS(CELL_NUMS_IF)
  ) u_if_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr   (if_clr),
    .inc   (if_wr),
    .q     (write_addr_if),
    .q_next(if_q_next)
  );

  always_comb begin
    filter_words = sat_size(32'(filter_size), CELL_NUMS_FILTER);
    // One slot always stays empty so equal pointers unambiguously mean empty.
    if_full      = (if_q_next == start_if);
    if_wr        = rst && (state_q == StStream) && !if_fifo_empty && !if_full;
    filter_wr    = rst && (state_q == StFilter) && !filter_fifo_empty;
    filter_last  = (32'(filter_q_next) == filter_words);
  end

  always_comb begin
    state_d         = state_q;
    filter_loaded_d = filter_loaded_q;
    if_clr          = 1'b0;
    filter_clr      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d         = StFilter;
          if_clr          = 1'b1;
          filter_clr      = 1'b1;
          filter_loaded_d = 1'b0;
        end
      end
      StFilter: begin
        if (filter_wr && filter_last) begin
          state_d         = StStream;
          filter_loaded_d = 1'b1;
        end
      end
      StStream: begin
        if (done_in) begin
          state_d = StDone;
        end else if (filter_reload) begin
          state_d         = StFilter;
          filter_clr      = 1'b1;
          filter_loaded_d = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= StIdle;
      filter_loaded_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      filter_loaded_q <= filter_loaded_d;
    end
  end

  always_comb begin
    if_fifo_rd     = if_wr;
    if_wen         = if_wr;
    if_wdata       = if_fifo_dout;
    filter_fifo_rd = filter_wr;
    filter_wen     = filter_wr;
    filter_wdata   = filter_fifo_dout;
    filter_loaded  = filter_loaded_q;
    busy           = (state_q != StIdle);
  end

endmodule

// File: tb/tb_scratch_write_controller.sv
// Self-checking bench for scratch_write_controller: directed layer sequence then
// randomized control/FIFO traffic compared against a phase-level reference model.
module tb_scratch_write_controller;

  localparam int Depth   = 8;
  localparam int PIdle   = 0;
  localparam int PFilter = 1;
  localparam int PStream = 2;
  localparam int PDone   = 3;

  logic       clk = 1'b0;
  logic       rst, start, filter_reload, done_in;
  logic [2:0] filter_size;
  logic [7:0] start_if;
  logic       if_fifo_empty, filter_fifo_empty;
  logic [7:0] if_fifo_dout, filter_fifo_dout;
  logic       if_fifo_rd, filter_fifo_rd, if_wen, filter_wen;
  logic [7:0] if_wdata, filter_wdata, write_addr_if, write_addr_filter;
  logic       filter_loaded, if_full, busy;

  always #5 clk = ~clk;

  scratch_write_controller dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .filter_size      (filter_size),
    .filter_reload    (filter_reload),
    .done_in          (done_in),
    .start_if         (start_if),
    .if_fifo_empty    (if_fifo_empty),
    .if_fifo_dout     (if_fifo_dout),
    .filter_fifo_empty(filter_fifo_empty),
    .filter_fifo_dout (filter_fifo_dout),
    .if_fifo_rd       (if_fifo_rd),
    .filter_fifo_rd   (filter_fifo_rd),
    .if_wen           (if_wen),
    .if_wdata         (if_wdata),
    .write_addr_if    (write_addr_if),
    .filter_wen       (filter_wen),
    .filter_wdata     (filter_wdata),
    .write_addr_filter(write_addr_filter),
    .filter_loaded    (filter_loaded),
    .if_full          (if_full),
    .busy             (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_phase  = PIdle;
  int m_if_ptr = 0;
  int m_f_ptr  = 0;
  bit m_loaded = 1'b0;

  logic [7:0] ifq[$];
  logic [7:0] fq[$];
  bit hold_if  = 1'b0;
  bit hold_f   = 1'b0;
  bit f_refill = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: present FIFOs, compare outputs mid-cycle, then advance model at the edge.
  task automatic tick();
    int eff;
    bit full, e_if, e_f, got_if_rd, got_f_rd;
    if (ifq.size() < 4) repeat (4) ifq.push_back(8'($urandom));
    if (f_refill && fq.size() < 2) repeat (2) fq.push_back(8'($urandom));
    if_fifo_empty     = hold_if || (ifq.size() == 0);
    if_fifo_dout      = (ifq.size() != 0) ? ifq[0] : 8'h00;
    filter_fifo_empty = hold_f || (fq.size() == 0);
    filter_fifo_dout  = (fq.size() != 0) ? fq[0] : 8'h00;
    #1;
    eff  = (filter_size == 3'd0) ? Depth : int'(filter_size);
    full = (((m_if_ptr + 1) % Depth) == int'(start_if));
    e_if = rst && (m_phase == PStream) && !if_fifo_empty && !full;
    e_f  = rst && (m_phase == PFilter) && !filter_fifo_empty;
    check_eq("busy", 32'(busy), 32'(m_phase != PIdle));
    check_eq("write_addr_if", 32'(write_addr_if), 32'(m_if_ptr));
    check_eq("write_addr_filter", 32'(write_addr_filter), 32'(m_f_ptr));
    check_eq("filter_loaded", 32'(filter_loaded), 32'(m_loaded));
    check_eq("if_full", 32'(if_full), 32'(full));
    check_eq("if_wen", 32'(if_wen), 32'(e_if));
    check_eq("if_fifo_rd", 32'(if_fifo_rd), 32'(e_if));
    check_eq("filter_wen", 32'(filter_wen), 32'(e_f));
    check_eq("filter_fifo_rd", 32'(filter_fifo_rd), 32'(e_f));
    if (e_if) check_eq("if_wdata", 32'(if_wdata), 32'(ifq[0]));
    if (e_f) check_eq("filter_wdata", 32'(filter_wdata), 32'(fq[0]));
    got_if_rd = if_fifo_rd;
    got_f_rd  = filter_fifo_rd;
    @(posedge clk);
    if (got_if_rd && ifq.size() != 0) void'(ifq.pop_front());
    if (got_f_rd && fq.size() != 0) void'(fq.pop_front());
    if (!rst) begin
      m_phase  = PIdle;
      m_if_ptr = 0;
      m_f_ptr  = 0;
      m_loaded = 1'b0;
    end else begin
      case (m_phase)
        PIdle: if (start) begin
          m_phase  = PFilter;
          m_if_ptr = 0;
          m_f_ptr  = 0;
          m_loaded = 1'b0;
        end
        PFilter: if (e_f) begin
          if (m_f_ptr == eff - 1) begin
            m_phase  = PStream;
            m_loaded = 1'b1;
          end
          m_f_ptr++;
        end
        PStream: begin
          if (e_if) m_if_ptr = (m_if_ptr + 1) % Depth;
          if (done_in) m_phase = PDone;
          else if (filter_reload) begin
            m_phase  = PFilter;
            m_f_ptr  = 0;
            m_loaded = 1'b0;
          end
        end
        default: m_phase = PIdle;
      endcase
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; filter_reload = 1'b0; done_in = 1'b0;
    filter_size = 3'd3; start_if = 8'd0;
    if_fifo_empty = 1'b1; filter_fifo_empty = 1'b1;
    if_fifo_dout = 8'h00; filter_fifo_dout = 8'h00;
    repeat (2) @(negedge clk);
    tick();

    // Layer start with a 3-word filter
    rst = 1'b1;
    repeat (3) fq.push_back(8'($urandom));
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    check_eq("loaded_after_3", 32'(filter_loaded), 32'd1);
    check_eq("addr_filter_3", 32'(write_addr_filter), 32'd3);

    // Fill until one slot short of start_if=0
    repeat (10) tick();
    check_eq("stall_addr_7", 32'(write_addr_if), 32'd7);
    check_eq("stall_full", 32'(if_full), 32'd1);

    // Read pointer moves to 3: wrap through 0,1 and stall at 2
    start_if = 8'd3;
    repeat (10) tick();
    check_eq("wrap_stall_addr_2", 32'(write_addr_if), 32'd2);
    check_eq("wrap_stall_full", 32'(if_full), 32'd1);

    // Empty every other cycle
    start_if = 8'd2;
    for (int i = 0; i < 8; i++) begin
      hold_if = (i % 2 == 0);
      tick();
    end
    hold_if = 1'b0;
    check_eq("alt_addr_6", 32'(write_addr_if), 32'd6);

    // Filter reload mid-stream with the filter FIFO dry at first
    filter_size = 3'd2;
    filter_reload = 1'b1; tick(); filter_reload = 1'b0;
    repeat (2) tick();
    check_eq("reload_waiting", 32'(filter_loaded), 32'd0);
    check_eq("reload_if_hold", 32'(write_addr_if), 32'd7);
    repeat (2) fq.push_back(8'($urandom));
    repeat (2) tick();
    check_eq("reload_loaded", 32'(filter_loaded), 32'd1);

    // Reset while filter writes are active
    filter_reload = 1'b1; tick(); filter_reload = 1'b0;
    repeat (2) fq.push_back(8'($urandom));
    rst = 1'b0; tick(); rst = 1'b1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_addr_if", 32'(write_addr_if), 32'd0);
    check_eq("rst_addr_filter", 32'(write_addr_filter), 32'd0);
    check_eq("rst_filter_wen", 32'(filter_wen), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    check_eq("restart_loaded", 32'(filter_loaded), 32'd1);

    // done_in ends the layer after one DONE cycle
    done_in = 1'b1; tick(); done_in = 1'b0;
    check_eq("done_busy", 32'(busy), 32'd1);
    tick();
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Randomized traffic
    f_refill = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      rst           = ($urandom_range(0, 99) != 0);
      start         = ($urandom_range(0, 99) < 8);
      done_in       = ($urandom_range(0, 99) < 3);
      filter_reload = ($urandom_range(0, 99) < 3);
      if (m_phase == PIdle && $urandom_range(0, 99) < 20) filter_size = 3'($urandom);
      if ($urandom_range(0, 99) < 15) start_if = 8'($urandom_range(0, Depth - 1));
      hold_if = ($urandom_range(0, 99) < 30);
      hold_f  = ($urandom_range(0, 99) < 30);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
